accel_job_scheduler: RTL

Round-robin scheduler sharing the single crypto accelerator core between two requesters: the Wishbone-side register interface and the logic-analyzer debug path. Sits between both request sources and the core's start/done port, inside the accelerator top level. Grants one job at a time, launches it, tracks completion and returns done/error to the owning requester. An optional watchdog aborts hung jobs.

---
 rtl/accel_job_scheduler_if.sv | 35 +++
 rtl/accel_job_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/accel_job_scheduler_if.sv
// Bundles the two requester handshakes and the core start/done port of accel_job_scheduler.
// The slave modport is the scheduler's view; master is the view of the requesters and the core.
`timescale 1ns/1ps
interface accel_job_scheduler_if #(
  parameter int OPW = 8
);
  logic           wb_req_i;
  logic [OPW-1:0] wb_op_i;
  logic           wb_gnt_o;
  logic           wb_done_o;
  logic           wb_err_o;
  logic           la_req_i;
  logic [OPW-1:0] la_op_i;
  logic           la_gnt_o;
  logic           la_done_o;
  logic           la_err_o;
  logic           core_start_o;
  logic [OPW-1:0] core_op_o;
  logic           core_done_i;
  logic           core_abort_o;
  logic           busy_o;
  logic           owner_o;

  modport slave (
    input  wb_req_i, wb_op_i, la_req_i, la_op_i, core_done_i,
    output wb_gnt_o, wb_done_o, wb_err_o, la_gnt_o, la_done_o, la_err_o,
           core_start_o, core_op_o, core_abort_o, busy_o, owner_o
  );

  modport master (
    output wb_req_i, wb_op_i, la_req_i, la_op_i, core_done_i,
    input  wb_gnt_o, wb_done_o, wb_err_o, la_gnt_o, la_done_o, la_err_o,
           core_start_o, core_op_o, core_abort_o, busy_o, owner_o
  );
endinterface

// File: rtl/accel_job_scheduler.sv
// Round-robin job scheduler sharing one crypto core between the Wishbone and LA requesters.
// Define ACCEL_WATCHDOG_EN to build the RUN-state watchdog (abort + error after TIMEOUT cycles).
`timescale 1ns/1ps
module accel_job_scheduler #(
  parameter int OPW     = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  accel_job_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_owner;
  logic           r_last;
  logic [OPW-1:0] r_op;
  logic           w_grant;
  logic           w_pick_la;
  logic           w_timeout;
  logic           w_in_start;
  logic           w_in_done;

`ifdef ACCEL_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_abort;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_pick_la   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.wb_req_i || bus.la_req_i) begin
          w_grant     = 1'b1;
          // On a tie the requester that was not served last wins.
          w_pick_la   = bus.la_req_i && (!bus.wb_req_i || !r_last);
          w_state_nxt = S_START;
        end
      end
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.core_done_i || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_op    <= w_pick_la ? bus.la_op_i : bus.wb_op_i;
        r_owner <= w_pick_la;
        r_last  <= w_pick_la;
      end
    end
  end

`ifdef ACCEL_WATCHDOG_EN
  // Abort/err are registered so a done arriving on the limit cycle can still cancel them.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == S_RUN) && (w_state_nxt == S_DONE)) begin
        r_err   <= !bus.core_done_i;
        r_abort <= !bus.core_done_i;
      end
    end
  end

  assign bus.wb_err_o     = w_in_done && !r_owner && r_err;
  assign bus.la_err_o     = w_in_done &&  r_owner && r_err;
  assign bus.core_abort_o = r_abort;
`else
  assign bus.wb_err_o     = 1'b0;
  assign bus.la_err_o     = 1'b0;
  assign bus.core_abort_o = 1'b0;
`endif

  assign w_in_start       = (r_state == S_START);
  assign w_in_done        = (r_state == S_DONE);
  assign bus.wb_gnt_o     = w_in_start && !r_owner;
  assign bus.la_gnt_o     = w_in_start &&  r_owner;
  assign bus.wb_done_o    = w_in_done  && !r_owner;
  assign bus.la_done_o    = w_in_done  &&  r_owner;
  assign bus.core_start_o = w_in_start;
  assign bus.core_op_o    = r_op;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.owner_o      = r_owner;

endmodule
